// File: rtl/vga_scan_out.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_scan_out: pixel FIFO, raster timing and SOF-aligned VGA DAC output stage.
// Revision 1.0
// ----------------------------------------------------------------------------
module vga_scan_out #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] pix_data,
  input  logic        pix_sof,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic        frame_start,
  output logic        underflow,
  input  logic        underflow_clr
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Raster counters
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap;
  logic          active;
  logic          origin;
  logic          hs_zone;
  logic          vs_zone;

  assign h_wrap  = (h_cnt == H_LAST);
  assign active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign origin  = (h_cnt == '0) && (v_cnt == '0);
  assign hs_zone = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
  assign vs_zone = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      if (h_wrap) begin
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end
    end
  end

  // Pixel FIFO, entries are {sof, rgb}
  logic [24:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;
  logic          empty;
  logic [24:0]   head;

  assign push  = pix_valid && pix_ready;
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {pix_sof, pix_data};
    end
  end

  // Ready is registered so it sits low through reset and never sees a same-cycle pop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pix_ready <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count     <= count_nxt;
      pix_ready <= (count_nxt != DEPTH_C);
    end
  end

  // Frame alignment state machine
  state_t state;
  state_t state_nxt;
  logic   show;
  logic   err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SYNC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    show      = 1'b0;
    err       = 1'b0;
    case (state)
      SYNC: begin
        if (!empty) begin
          if (!head[24]) begin
            pop = 1'b1;
          end else if (origin) begin
            pop       = 1'b1;
            show      = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (active) begin
          // A misplaced or missing sof stays in the FIFO to realign the next frame
          if (empty || (head[24] != origin)) begin
            err       = 1'b1;
            state_nxt = SYNC;
          end else begin
            pop  = 1'b1;
            show = 1'b1;
          end
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  // Output register stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= show ? head[23:0] : 24'h000000;
      vga_hs      <= !hs_zone;
      vga_vs      <= !vs_zone;
      vga_blank_n <= active;
      frame_start <= origin;
      if (err) begin
        underflow <= 1'b1;
      end else if (underflow_clr) begin
        underflow <= 1'b0;
      end
    end
  end

  assign vga_sync_n = 1'b0;

endmodule
`default_nettype wire

// File: doc/vga_scan_out.md
# vga_scan_out

Final VGA output stage of the display path. Consumes a 24-bit RGB pixel stream through a valid/ready handshake, buffers it in a small FIFO, and generates the raster timing. Its outputs drive the VGA DAC pins (vga_r/g/b, vga_hs, vga_vs, vga_blank_n, vga_sync_n). Frame alignment uses a start-of-frame marker carried with the stream, with automatic resynchronisation after underflow.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- FIFO_DEPTH, 16, pixel FIFO entries (power of two)

Ports:
- clk  in  1  pixel clock (25 MHz for the defaults)
- reset_n  in  1  asynchronous, active-low reset
- pix_data  in  24  {R[23:16], G[15:8], B[7:0]}
- pix_sof  in  1  marks the first pixel of a frame
- pix_valid  in  1  upstream has a pixel
- pix_ready  out  1  FIFO can accept; transfer occurs when valid && ready
- vga_r, vga_g, vga_b  out  8 each  pixel colour
- vga_hs, vga_vs  out  1  syncs, active-low
- vga_blank_n  out  1  high during the visible region
- vga_sync_n  out  1  constant 0 (no sync-on-green)
- frame_start  out  1  one-cycle pulse at h=0, v=0
- underflow  out  1  sticky error flag
- underflow_clr  in  1  clears underflow; set has priority over clear in the same cycle

## Operation
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1.
  - Both are 0 after reset.
- Active region: h_cnt < H_ACTIVE && v_cnt < V_ACTIVE.
- hs low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. vs uses the same rule on v_cnt.
- FIFO:
  - Each entry is 25 bits: {sof, rgb}.
  - pix_ready = (count != FIFO_DEPTH); it does not depend on a same-cycle pop.
  - Simultaneous push and pop leaves count unchanged.
- State machine, SYNC (reset state) and RUN:
  - SYNC: pop and discard any head entry with sof=0, at any time. Hold a head entry with sof=1. Output black in the active region. Go to RUN on the cycle h_cnt=0, v_cnt=0 if the head is a valid sof entry; that pixel is popped and displayed in the same cycle.
  - RUN: pop exactly one entry per active cycle and display it.
  - Underflow (FIFO empty in an active cycle): display 0x000000, set underflow, go to SYNC.
  - Early sof (head has sof=1 at any active position other than (0,0)): do not pop, display black, set underflow, go to SYNC. The held entry then aligns the next frame.
  - RUN reaching (0,0) with a sof=0 head is handled as an early-sof-type error: black, underflow, SYNC.
- Pixel colour outside the active region is forced to 0.
- Reset mid-frame clears counters, FIFO, and state immediately. Outputs go to their reset values asynchronously.

## Timing
- Outputs are all registered. vga_* and frame_start reflect the counter state of the previous cycle, so colour, hs, vs, and blank_n are mutually aligned with 1-cycle latency from the counters.
- Input to output latency: at least 2 clocks (FIFO write, then pop at the next scheduled active position, then the output register).
- Reset values:
  - vga_r/g/b = 0, vga_hs = 1, vga_vs = 1, vga_blank_n = 0, vga_sync_n = 0
  - frame_start = 0, underflow = 0
  - pix_ready = 0 while reset_n is low; 1 on the first clock after release.
- Frame period for the defaults: 800 × 525 = 420000 clocks. frame_start fires once per frame, one cycle after h=v=0.

## Test plan
- Reset release, no input: pix_ready=1. hs low for 96 clocks every 800. vs low for 2 lines every 525. blank_n high for 640 clocks on lines 0–479. RGB stays 0. underflow stays 0, because SYNC does not flag errors.
- Continuous stream, sof on the first pixel, value = pixel index: the first blank_n=1 cycle shows 0x000000, then 0x000001…, with no underflow across 3 frames.
- Stall upstream for 20 clocks mid-line 100 in RUN: black pixels appear, underflow=1, and the state returns to SYNC. Resume the stream with sof: the next frame displays correctly. underflow_clr then drops the flag.
- Send 5 junk pixels (sof=0) before a sof frame: the junk is discarded and the display starts cleanly at the following (0,0).
- sof injected at pixel 300 of line 10: black from that pixel, underflow=1, and the held sof aligns the next frame at (0,0).
- Assert reset_n low mid-line: all outputs take their reset values immediately and the FIFO is empty after release.
